// File: rtl/nibble_add_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_add_sched_if                                          |
// | Description : Bundle of the two requester channels and the response        |
// |               channel of nibble_add_sched.                                 |
// |               master : the client side (drives valids, operands,           |
// |                        rsp_ready; observes readies and results)            |
// |               slave  : the scheduler side                                  |
// | Ports       : req0_valid/ready/a/b, req1_valid/ready/a/b,                  |
// |               rsp_valid/ready/sum/cout/id, busy                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface nibble_add_sched_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;

  logic         busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/nibble_add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_add_sched                                             |
// | Description : Round-robin scheduler sharing one 4-bit ripple-carry adder   |
// |               between two requesters. An accepted operand pair is added    |
// |               serially, one nibble per cycle LSB first, with a registered  |
// |               carry; the result is returned on a valid/ready channel.      |
// | Ports       : clk  - clock, rising edge                                    |
// |               rst  - asynchronous active-high reset                        |
// |               bus  - nibble_add_sched_if.slave (requests, response, busy)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nibble_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  nibble_add_sched_if.slave   bus
);

  localparam int W     = 4 * NIBBLES;
  // Index register needs at least one bit even when NIBBLES == 1.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q,  prio_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic [W-1:0]     sum_q,   sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             cout_q,  cout_d;
  logic             id_q,    id_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;

  // --------------------------------------------------------------------------
  // Arbitration: a lone valid wins; on contention prio names the winner.
  // --------------------------------------------------------------------------
  logic grant0;
  logic grant1;

  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  prio_q);

  assign bus.req0_ready = (state_q == ST_IDLE) & grant0;
  assign bus.req1_ready = (state_q == ST_IDLE) & grant1;

  assign bus.rsp_valid = valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = busy_q;

  // --------------------------------------------------------------------------
  // Operand nibble selection for the current index.
  // --------------------------------------------------------------------------
  logic [3:0] add_a;
  logic [3:0] add_b;

  always_comb begin
    add_a = 4'd0;
    add_b = 4'd0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        add_a = a_q[4*k +: 4];
        add_b = b_q[4*k +: 4];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shared 4-bit ripple-carry adder; carry-in comes from the carry register.
  // --------------------------------------------------------------------------
  logic [3:0] add_s;
  logic [4:0] add_c;

  assign add_c[0] = carry_q;

  for (genvar i = 0; i < 4; i++) begin : g_ripple
    assign add_s[i]   = add_a[i] ^ add_b[i] ^ add_c[i];
    assign add_c[i+1] = (add_a[i] & add_b[i]) | (add_c[i] & (add_a[i] ^ add_b[i]));
  end

  // --------------------------------------------------------------------------
  // Next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    id_d    = id_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        // A grant in IDLE is the handshake: ready equals the grant here.
        if (grant0 | grant1) begin
          a_d     = grant1 ? bus.req1_a : bus.req0_a;
          b_d     = grant1 ? bus.req1_b : bus.req0_b;
          id_d    = grant1;
          prio_d  = ~grant1;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ST_ADD;
          busy_d  = 1'b1;
        end
      end

      ST_ADD: begin
        for (int k = 0; k < NIBBLES; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[4*k +: 4] = add_s;
          end
        end
        carry_d = add_c[4];
        if (idx_q == LAST_IDX) begin
          cout_d  = add_c[4];
          idx_d   = '0;
          state_d = ST_RESP;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nibble_add_sched                                          |
// | Description : Self-checking bench for nibble_add_sched: directed cases     |
// |               and randomized traffic against a transaction-level model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nibble_add_sched;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_add_sched_if #(.NIBBLES(N)) bus ();

  nibble_add_sched #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Transaction-level model: who has priority, whether an op is in flight,
  // its expected result and the cycle its response is due.
  bit           m_prio;
  bit           m_busy;
  int           m_due;
  logic [W-1:0] m_sum;
  bit           m_cout;
  bit           m_id;

  int  n_acc = 0;
  int  n_rsp = 0;
  bit  acc0, acc1;
  int  last_acc_cyc, last_rsp_cyc;
  bit  keep_valid;

  logic [W-1:0] log_sum[$];
  bit           log_cout[$];
  bit           log_id[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; sample at the falling edge,
  // compare with the model, then return just after the next rising edge.
  task automatic step();
    bit           v0, v1, g0, g1;
    logic [W:0]   full;
    @(negedge clk);
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_busy) begin
      g0 = v0 && (!v1 || !m_prio);
      g1 = v1 && (!v0 ||  m_prio);
      chk("req0_ready", bus.req0_ready, g0);
      chk("req1_ready", bus.req1_ready, g1);
      chk("rsp_valid_idle", bus.rsp_valid, 0);
      chk("busy_idle", bus.busy, 0);
      if (g0 || g1) begin
        full   = g1 ? ({1'b0, bus.req1_a} + {1'b0, bus.req1_b})
                    : ({1'b0, bus.req0_a} + {1'b0, bus.req0_b});
        m_sum  = full[W-1:0];
        m_cout = full[W];
        m_id   = g1;
        m_due  = cyc + N + 1;
        m_busy = 1'b1;
        m_prio = !g1;
        n_acc++;
        last_acc_cyc = cyc;
      end
    end else begin
      chk("req0_ready_busy", bus.req0_ready, 0);
      chk("req1_ready_busy", bus.req1_ready, 0);
      chk("busy_active", bus.busy, 1);
      if (cyc < m_due) begin
        chk("rsp_valid_early", bus.rsp_valid, 0);
      end else begin
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_sum", bus.rsp_sum, m_sum);
        chk("rsp_cout", bus.rsp_cout, m_cout);
        chk("rsp_id", bus.rsp_id, m_id);
        if (bus.rsp_ready) begin
          log_sum.push_back(bus.rsp_sum);
          log_cout.push_back(bus.rsp_cout);
          log_id.push_back(bus.rsp_id);
          m_busy = 1'b0;
          n_rsp++;
          last_rsp_cyc = cyc;
        end
      end
    end
    acc0 = g0;
    acc1 = g1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rsps(input int n);
    int target;
    int guard;
    target = n_rsp + n;
    guard  = 0;
    while (n_rsp < target && guard < 80 * n) begin
      step();
      if (!keep_valid) begin
        if (acc0) bus.req0_valid = 1'b0;
        if (acc1) bus.req1_valid = 1'b0;
      end
      guard++;
    end
    if (n_rsp < target) chk("rsp_timeout", n_rsp, target);
  endtask

  task automatic single_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_sum, input bit exp_cout, input string tag);
    log_sum.delete(); log_cout.delete(); log_id.delete();
    keep_valid = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    run_rsps(1);
    if (log_sum.size() == 1) begin
      chk({tag, "_sum"},  log_sum[0],  exp_sum);
      chk({tag, "_cout"}, log_cout[0], exp_cout);
      chk({tag, "_id"},   log_id[0],   id);
    end else begin
      chk({tag, "_count"}, log_sum.size(), 1);
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      default: return r[W-1:0];
    endcase
  endfunction

  initial begin
    int start_acc;
    int guard;

    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;
    m_prio = 1'b0;
    m_busy = 1'b0;
    keep_valid = 1'b0;

    #12;
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_sum",   bus.rsp_sum,   0);
    chk("reset_rsp_cout",  bus.rsp_cout,  0);
    chk("reset_rsp_id",    bus.rsp_id,    0);
    chk("reset_busy",      bus.busy,      0);
    chk("reset_req0_ready", bus.req0_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Contention straight out of reset, both valids held continuously.
    log_sum.delete(); log_cout.delete(); log_id.delete();
    keep_valid = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h3333; bus.req1_b = 16'h4444;
    run_rsps(4);
    if (log_id.size() == 4) begin
      chk("contend_sum0", log_sum[0], 16'h3333);
      chk("contend_sum1", log_sum[1], 16'h7777);
      for (int i = 0; i < 4; i++) chk($sformatf("contend_id%0d", i), log_id[i], i % 2);
    end else begin
      chk("contend_count", log_id.size(), 4);
    end
    keep_valid = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Directed arithmetic cases.
    single_op(1'b0, 16'h0001, 16'h0006, 16'h0007, 1'b0, "single");
    single_op(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "chain");
    single_op(1'b0, 16'h8000, 16'h9000, 16'h1000, 1'b1, "msb_carry");
    single_op(1'b1, 16'h0F0F, 16'h0101, 16'h1010, 1'b0, "mid_carry");

    // Back-pressure: stall in RESP for 10 cycles with both requesters waiting.
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h1111;
    guard = 0;
    do begin
      step();
      if (acc0) bus.req0_valid = 1'b0;
      guard++;
    end while (!(m_busy && cyc > m_due) && guard < 40);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0002; bus.req0_b = 16'h0003;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0004; bus.req1_b = 16'h0005;
    for (int i = 0; i < 10; i++) step();
    chk("bp_still_pending", n_rsp, n_acc - 1);
    bus.rsp_ready = 1'b1;
    step();
    step();
    chk("bp_next_accept_gap", last_acc_cyc - last_rsp_cyc, 1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    run_rsps(1);
    for (int i = 0; i < 3; i++) step();

    // Reset during ADD: op from requester 0 leaves prio pointing at 1.
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0F0F; bus.req0_b = 16'h0F0F;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!acc0 && guard < 20);
    bus.req0_valid = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_sum",   bus.rsp_sum,   0);
    chk("arst_rsp_cout",  bus.rsp_cout,  0);
    chk("arst_rsp_id",    bus.rsp_id,    0);
    chk("arst_busy",      bus.busy,      0);
    chk("arst_req1_ready", bus.req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if (m_busy) n_acc--;
    m_busy = 1'b0;
    m_prio = 1'b0;
    cyc = cyc + 2;
    @(posedge clk);
    #1;
    log_sum.delete(); log_cout.delete(); log_id.delete();
    bus.req0_valid = 1'b1; bus.req0_a = 16'hAAAA; bus.req0_b = 16'h5555;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0000; bus.req1_b = 16'h0001;
    run_rsps(2);
    if (log_id.size() == 2) begin
      chk("post_rst_sum",  log_sum[0],  16'hFFFF);
      chk("post_rst_cout", log_cout[0], 0);
      chk("post_rst_id",   log_id[0],   0);
      chk("post_rst_id2",  log_id[1],   1);
    end else begin
      chk("post_rst_count", log_id.size(), 2);
    end

    // Randomized traffic.
    start_acc = n_acc;
    for (int i = 0; i < 20000 && (n_acc - start_acc) < 1000; i++) begin
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = ($urandom_range(0, 1) == 1);
        bus.req0_a = rnd_opnd();
        bus.req0_b = rnd_opnd();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.req0_valid = 1'b0;
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = ($urandom_range(0, 1) == 1);
        bus.req1_a = rnd_opnd();
        bus.req1_b = rnd_opnd();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.req1_valid = 1'b0;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("random_ops_done", n_acc - start_acc >= 1000, 1);

    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < 2 * N + 4; i++) step();
    chk("no_lost_rsp", n_rsp, n_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
